axis_traffic_gen: RTL and testbench
===================================

# axis_traffic_gen

Synthesizable, parametrised AXI-Stream packet source for exercising the NoC meshes in hardware and in simulation, replacing hand-scripted per-cycle stimulus. On a start command it emits a programmed number of multi-flit packets, round-robin over a destination mask. Each packet has a configurable flit count and inter-packet gap. Every flit carries a self-describing payload so a downstream checker can verify source, destination, sequence and ordering. One instance sits on each `axis_in_*` port of an `axis_mesh`.

## Interface
- `TDEST_WIDTH`, 4: width of `tdest`; destination index space.
- `TDATA_WIDTH`, 512: flit width; must be ≥ 48.
- `NUM_DESTS`, 4: number of destinations addressable by the mask; must be ≤ 2^TDEST_WIDTH.
- `SRC_ID`, 0: 8-bit source identifier stamped into every flit.
- `LEN_WIDTH`, 8: width of `pkt_len`.

- `clk` in 1: single clock; all logic is on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle command; sampled only in IDLE.
- `stop` in 1: level; requests early termination at the next packet boundary.
- `num_packets` in 16: number of packets to send; latched on `start`.
- `pkt_len` in LEN_WIDTH: flits per packet; latched on `start`; 0 is treated as 1.
- `gap` in 8: idle cycles inserted after each packet except the last; latched on `start`.
- `dest_mask` in NUM_DESTS: eligible destinations; latched on `start`.
- `busy` out 1: high while a run is active.
- `done` out 1: one-cycle pulse marking the end of a run.
- `pkt_count` out 16: number of packets completed (count of `tlast` handshakes) in the current or last run.
- `axis_out_tvalid` out 1: AXI-Stream valid.
- `axis_out_tready` in 1: AXI-Stream ready.
- `axis_out_tdata` out TDATA_WIDTH: flit payload.
- `axis_out_tlast` out 1: marks the final flit of a packet.
- `axis_out_tdest` out TDEST_WIDTH: packet destination.

## Operation
- FSM states: IDLE, SEND, GAP, DONE.
- **IDLE**
  - `start`=1 latches the configuration, clears `pkt_count`, sequence number and flit index, selects the first destination, then → SEND.
  - If `num_packets`==0 or `dest_mask`==0, → DONE instead.
- **SEND**
  - `tvalid`=1.
  - Flit index increments on each handshake (`tvalid & tready`).
  - `tlast`=1 when flit index == effective length − 1.
- **On a `tlast` handshake**
  - `pkt_count` and sequence number increment; flit index clears.
  - Destination advances to the next set mask bit above the current one, wrapping modulo NUM_DESTS.
  - Exit: → DONE if this was packet `num_packets` or `stop`=1; otherwise → GAP if `gap`≠0; otherwise stay in SEND.
- **GAP**: `tvalid`=0; a down-counter loaded with `gap` runs to 1, then → SEND.
- **DONE**: `done`=1 and `busy`=0 for exactly one cycle, then → IDLE.
- **First destination**: the lowest set bit of `dest_mask`. `tdest` is that bit index, zero-extended to TDEST_WIDTH.
- **Payload fields** (all other bits are 0):
  - `tdata[15:0]` = flit index.
  - `tdata[31:16]` = packet sequence number (0-based).
  - `tdata[39:32]` = `tdest`, zero-extended.
  - `tdata[47:40]` = SRC_ID.
- **AXI-Stream rules**
  - Once `tvalid` rises, `tvalid`, `tdata`, `tlast` and `tdest` hold stable until the handshake.
  - `tvalid` never depends combinationally on `tready`.
- **`stop` handling**: `stop` never truncates a packet. `stop` asserted in GAP → DONE on the next cycle. `stop` in IDLE has no effect.
- **`start` handling**: `start` outside IDLE is ignored. Configuration inputs may change freely after they are latched.
- **Counter widths**: sequence number, flit index and `pkt_count` are 16 bits. `num_packets` = 65535 completes without wrap.

## Timing
- Reset values:
  - `busy`, `done`, `axis_out_tvalid`, `axis_out_tlast` = 0.
  - `axis_out_tdata`, `axis_out_tdest`, `pkt_count` = 0.
  - FSM in IDLE.
- Reset asserted mid-run: all outputs return to reset values immediately. No `done` pulse is produced. `start` is accepted on the first edge after deassertion.
- `start` sampled at edge N → `busy`=1 and `tvalid`=1 from edge N+1.
- Degenerate start (`num_packets`==0 or `dest_mask`==0): `done` is high in cycle N+1 only; `busy` stays 0.
- With `tready` held high, throughput is 1 flit/cycle.
- `gap`=0: no bubble between packets.
- `gap`=g: `tvalid` is low for exactly g cycles after the `tlast` handshake.
- Final `tlast` handshake at edge M → `done`=1 and `busy`=0 in cycle M+1; `tvalid`=0 from M+1. No trailing gap is inserted.
- `pkt_count` updates on the edge of the `tlast` handshake and holds after DONE until the next `start`.

## Test plan
- Reset then idle, `tready`=1 → all outputs 0; no `tvalid` for 20 cycles.
- `num_packets`=6, `pkt_len`=3, `gap`=0, `dest_mask`=4'b1011, `tready`=1:
  - 18 consecutive flits.
  - tdest sequence 0,1,3,0,1,3.
  - `tlast` on flits 2,5,…,17; seq 0..5.
  - `done` one cycle after the 18th flit; `pkt_count`=6.
- `gap`=2, `pkt_len`=1, `num_packets`=3 → `tvalid` pattern 1,0,0,1,0,0,1 then `done`.
- `tready` randomly toggled (50%) → payload and `tdest` stable while stalled; flit indices 0..L−1 in order; no lost or duplicated flits.
- `stop` raised mid packet 2 of 10 (`pkt_len`=4) → packet 2 completes all 4 flits; `done` next cycle; `pkt_count`=3.
- `num_packets`=0 → `done` pulse one cycle after `start`; `busy` and `tvalid` remain 0. Reset asserted mid-packet → outputs zero immediately; a new `start` runs normally.

Source files
------------

// File: rtl/axis_traffic_gen.sv
// AXI-Stream packet source: emits a programmed number of multi-flit packets,
// round-robin over a destination mask, with a self-describing payload per flit.
module axis_traffic_gen #(
  parameter int TDEST_WIDTH = 4,
  parameter int TDATA_WIDTH = 512,
  parameter int NUM_DESTS   = 4,
  parameter int SRC_ID      = 0,
  parameter int LEN_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic [15:0]            num_packets,
  input  logic [LEN_WIDTH-1:0]   pkt_len,
  input  logic [7:0]             gap,
  input  logic [NUM_DESTS-1:0]   dest_mask,
  output logic                   busy,
  output logic                   done,
  output logic [15:0]            pkt_count,
  output logic                   axis_out_tvalid,
  input  logic                   axis_out_tready,
  output logic [TDATA_WIDTH-1:0] axis_out_tdata,
  output logic                   axis_out_tlast,
  output logic [TDEST_WIDTH-1:0] axis_out_tdest
);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  state_t                 state_reg;
  logic [15:0]            cfg_num_reg;
  logic [LEN_WIDTH-1:0]   cfg_last_reg;
  logic [7:0]             cfg_gap_reg;
  logic [NUM_DESTS-1:0]   cfg_mask_reg;
  logic [15:0]            flit_idx_reg;
  logic [15:0]            seq_reg;
  logic [15:0]            pkt_count_reg;
  logic [TDEST_WIDTH-1:0] dest_reg;
  logic [7:0]             gap_cnt_reg;
  logic                   busy_reg;
  logic                   done_reg;
  logic                   tvalid_reg;

  logic [TDEST_WIDTH-1:0] first_dest;
  logic [TDEST_WIDTH-1:0] next_dest;
  logic                   next_found;
  logic                   last_flit;
  logic                   last_pkt;
  logic                   handshake;
  logic [TDATA_WIDTH-1:0] payload;

  // Descending scan so the lowest set bit is the one that sticks.
  always_comb begin
    first_dest = '0;
    for (int i = NUM_DESTS - 1; i >= 0; i--) begin
      if (dest_mask[i]) first_dest = TDEST_WIDTH'(i);
    end
  end

  // Scan upward from the current destination; k == NUM_DESTS lands back on itself.
  always_comb begin
    next_dest  = dest_reg;
    next_found = 1'b0;
    for (int k = 1; k <= NUM_DESTS; k++) begin
      if (!next_found && cfg_mask_reg[(int'(dest_reg) + k) % NUM_DESTS]) begin
        next_dest  = TDEST_WIDTH'((int'(dest_reg) + k) % NUM_DESTS);
        next_found = 1'b1;
      end
    end
  end

  assign last_flit = (flit_idx_reg == 16'(cfg_last_reg));
  assign last_pkt  = ((pkt_count_reg + 16'd1) == cfg_num_reg);
  assign handshake = tvalid_reg & axis_out_tready;

  // Payload is built only from registers, so it cannot move while stalled.
  always_comb begin
    payload = '0;
    if (tvalid_reg) begin
      payload[15:0]  = flit_idx_reg;
      payload[31:16] = seq_reg;
      payload[39:32] = 8'(dest_reg);
      payload[47:40] = 8'(SRC_ID);
    end
  end

  assign axis_out_tvalid = tvalid_reg;
  assign axis_out_tdata  = payload;
  assign axis_out_tlast  = tvalid_reg & last_flit;
  assign axis_out_tdest  = tvalid_reg ? dest_reg : '0;
  assign busy            = busy_reg;
  assign done            = done_reg;
  assign pkt_count       = pkt_count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      cfg_num_reg   <= '0;
      cfg_last_reg  <= '0;
      cfg_gap_reg   <= '0;
      cfg_mask_reg  <= '0;
      flit_idx_reg  <= '0;
      seq_reg       <= '0;
      pkt_count_reg <= '0;
      dest_reg      <= '0;
      gap_cnt_reg   <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      tvalid_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            cfg_num_reg   <= num_packets;
            cfg_last_reg  <= (pkt_len == '0) ? '0 : pkt_len - LEN_WIDTH'(1);
            cfg_gap_reg   <= gap;
            cfg_mask_reg  <= dest_mask;
            pkt_count_reg <= '0;
            seq_reg       <= '0;
            flit_idx_reg  <= '0;
            dest_reg      <= first_dest;
            if (num_packets == 16'd0 || dest_mask == '0) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg  <= SEND;
              busy_reg   <= 1'b1;
              tvalid_reg <= 1'b1;
            end
          end
        end

        SEND: begin
          if (handshake) begin
            if (last_flit) begin
              pkt_count_reg <= pkt_count_reg + 16'd1;
              seq_reg       <= seq_reg + 16'd1;
              flit_idx_reg  <= '0;
              dest_reg      <= next_dest;
              if (last_pkt || stop) begin
                state_reg  <= DONE;
                tvalid_reg <= 1'b0;
                busy_reg   <= 1'b0;
                done_reg   <= 1'b1;
              end else if (cfg_gap_reg != 8'd0) begin
                state_reg   <= GAP;
                tvalid_reg  <= 1'b0;
                gap_cnt_reg <= cfg_gap_reg;
              end
            end else begin
              flit_idx_reg <= flit_idx_reg + 16'd1;
            end
          end
        end

        GAP: begin
          if (stop) begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end else if (gap_cnt_reg <= 8'd1) begin
            state_reg  <= SEND;
            tvalid_reg <= 1'b1;
          end else begin
            gap_cnt_reg <= gap_cnt_reg - 8'd1;
          end
        end

        DONE: begin
          state_reg <= IDLE;
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
        end

        default: begin
          state_reg  <= IDLE;
          busy_reg   <= 1'b0;
          done_reg   <= 1'b0;
          tvalid_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_traffic_gen.sv
// Directed bench for axis_traffic_gen: hand-computed flit streams, gaps,
// back-pressure, early stop, degenerate starts and mid-run reset.
module tb_axis_traffic_gen;

  localparam int        TDW = 512;
  localparam logic [7:0] SRC = 8'h5A;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [15:0]   num_packets = '0;
  logic [7:0]    pkt_len = '0;
  logic [7:0]    gap = '0;
  logic [3:0]    dest_mask = '0;
  logic          busy;
  logic          done;
  logic [15:0]   pkt_count;
  logic          axis_out_tvalid;
  logic          axis_out_tready = 1'b1;
  logic [TDW-1:0] axis_out_tdata;
  logic          axis_out_tlast;
  logic [3:0]    axis_out_tdest;

  int checks = 0;
  int errors = 0;

  axis_traffic_gen #(
    .TDEST_WIDTH(4), .TDATA_WIDTH(TDW), .NUM_DESTS(4), .SRC_ID(90), .LEN_WIDTH(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .num_packets(num_packets), .pkt_len(pkt_len), .gap(gap), .dest_mask(dest_mask),
    .busy(busy), .done(done), .pkt_count(pkt_count),
    .axis_out_tvalid(axis_out_tvalid), .axis_out_tready(axis_out_tready),
    .axis_out_tdata(axis_out_tdata), .axis_out_tlast(axis_out_tlast),
    .axis_out_tdest(axis_out_tdest)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_word(input int idx, input int sq, input int dst);
    exp_word = {16'h0, SRC, 8'(dst), 16'(sq), 16'(idx)};
  endfunction

  // Drives a one-cycle start, then scrambles the config to prove it was latched.
  // Returns at the negedge of cycle N+1.
  task automatic start_run(input logic [15:0] n, input logic [7:0] len,
                           input logic [7:0] g, input logic [3:0] m);
    num_packets = n; pkt_len = len; gap = g; dest_mask = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0; num_packets = 16'hBEEF; pkt_len = 8'd7; gap = 8'd9; dest_mask = 4'b1111;
  endtask

  task automatic check_flit(input string tag, input int idx, input int sq, input int dst,
                            input logic lst);
    check({tag, "_valid"}, 64'(axis_out_tvalid), 64'd1);
    check({tag, "_data"}, axis_out_tdata[63:0], exp_word(idx, sq, dst));
    check({tag, "_hi"}, 64'(|axis_out_tdata[TDW-1:48]), 64'd0);
    check({tag, "_dest"}, 64'(axis_out_tdest), 64'(dst));
    check({tag, "_last"}, 64'(axis_out_tlast), 64'(lst));
    $display("flit %s seq=%0d idx=%0d dest=%0d last=%0b", tag,
             axis_out_tdata[31:16], axis_out_tdata[15:0], axis_out_tdest, axis_out_tlast);
  endtask

  initial begin
    int bad;
    int flits;
    int e_idx;
    int e_seq;
    bit seen;
    bit stalled;
    logic [63:0] held;
    logic [3:0] held_dest;
    logic r;
    logic [6:0] pat;
    int dseq_a [6];
    int dseq_r [3];
    dseq_a = '{0, 1, 3, 0, 1, 3};
    dseq_r = '{1, 2, 1};

    // Reset state and idle behaviour.
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_valid", 64'(axis_out_tvalid), 64'd0);
    check("rst_last", 64'(axis_out_tlast), 64'd0);
    check("rst_data", 64'(|axis_out_tdata), 64'd0);
    check("rst_dest", 64'(axis_out_tdest), 64'd0);
    check("rst_cnt", 64'(pkt_count), 64'd0);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (axis_out_tvalid || busy || done) bad++;
    end
    check("idle_quiet", 64'(bad), 64'd0);
    $display("test reset/idle complete");

    // 6 packets x 3 flits, mask 1011, no gap.
    axis_out_tready = 1'b1;
    start_run(16'd6, 8'd3, 8'd0, 4'b1011);
    check("a_busy", 64'(busy), 64'd1);
    check("a_cnt_clr", 64'(pkt_count), 64'd0);
    for (int i = 0; i < 18; i++) begin
      check_flit("a", i % 3, i / 3, dseq_a[i / 3], (i % 3) == 2);
      @(negedge clk);
    end
    check("a_done", 64'(done), 64'd1);
    check("a_busy_end", 64'(busy), 64'd0);
    check("a_valid_end", 64'(axis_out_tvalid), 64'd0);
    check("a_cnt", 64'(pkt_count), 64'd6);
    @(negedge clk);
    check("a_done_pulse", 64'(done), 64'd0);
    check("a_cnt_hold", 64'(pkt_count), 64'd6);

    // Gap of 2 between single-flit packets.
    pat = 7'b1001001;
    start_run(16'd3, 8'd1, 8'd2, 4'b0001);
    check("g_cnt_clr", 64'(pkt_count), 64'd0);
    for (int i = 0; i < 7; i++) begin
      check("g_valid", 64'(axis_out_tvalid), 64'(pat[6 - i]));
      if (i == 1) check("g_busy_gap", 64'(busy), 64'd1);
      @(negedge clk);
    end
    check("g_done", 64'(done), 64'd1);
    check("g_cnt", 64'(pkt_count), 64'd3);
    @(negedge clk);

    // pkt_len 0 behaves as single-flit packets.
    start_run(16'd2, 8'd0, 8'd0, 4'b1000);
    for (int i = 0; i < 2; i++) begin
      check_flit("z", 0, i, 3, 1'b1);
      @(negedge clk);
    end
    check("z_done", 64'(done), 64'd1);
    @(negedge clk);

    // Random back-pressure: 3 packets x 4 flits, gap 1, mask 0110.
    axis_out_tready = 1'b0;
    start_run(16'd3, 8'd4, 8'd1, 4'b0110);
    e_idx = 0; e_seq = 0; flits = 0; seen = 0; stalled = 0;
    held = '0; held_dest = '0;
    for (int c = 0; c < 400; c++) begin
      if (done) begin
        seen = 1;
        break;
      end
      if (stalled) begin
        check("r_stall_valid", 64'(axis_out_tvalid), 64'd1);
        check("r_stall_data", axis_out_tdata[63:0], held);
        check("r_stall_dest", 64'(axis_out_tdest), 64'(held_dest));
      end
      r = 1'($urandom_range(0, 1));
      axis_out_tready = r;
      if (axis_out_tvalid && r) begin
        check_flit("r", e_idx, e_seq, dseq_r[e_seq % 3], e_idx == 3);
        flits++;
        e_idx++;
        if (e_idx == 4) begin
          e_idx = 0;
          e_seq++;
        end
        stalled = 0;
      end else if (axis_out_tvalid) begin
        stalled = 1;
        held = axis_out_tdata[63:0];
        held_dest = axis_out_tdest;
      end else begin
        stalled = 0;
      end
      @(negedge clk);
    end
    check("r_done_seen", 64'(seen), 64'd1);
    check("r_flits", 64'(flits), 64'd12);
    check("r_cnt", 64'(pkt_count), 64'd3);
    axis_out_tready = 1'b1;
    @(negedge clk);

    // Early stop during packet 2 of 10.
    start_run(16'd10, 8'd4, 8'd0, 4'b0001);
    flits = 0; seen = 0;
    for (int c = 0; c < 100; c++) begin
      if (done) begin
        seen = 1;
        break;
      end
      if (axis_out_tvalid) begin
        flits++;
        if (axis_out_tdata[31:16] == 16'd2 && axis_out_tdata[15:0] == 16'd1) stop = 1'b1;
      end
      @(negedge clk);
    end
    check("s_done_seen", 64'(seen), 64'd1);
    check("s_flits", 64'(flits), 64'd12);
    check("s_cnt", 64'(pkt_count), 64'd3);
    check("s_busy", 64'(busy), 64'd0);
    stop = 1'b0;
    @(negedge clk);

    // Degenerate starts: zero packets, then empty mask.
    start_run(16'd0, 8'd3, 8'd0, 4'b0001);
    check("d0_done", 64'(done), 64'd1);
    check("d0_busy", 64'(busy), 64'd0);
    check("d0_valid", 64'(axis_out_tvalid), 64'd0);
    @(negedge clk);
    check("d0_done_pulse", 64'(done), 64'd0);
    check("d0_valid2", 64'(axis_out_tvalid), 64'd0);
    start_run(16'd5, 8'd3, 8'd0, 4'b0000);
    check("dm_done", 64'(done), 64'd1);
    check("dm_busy", 64'(busy), 64'd0);
    @(negedge clk);

    // Reset in packet 1, then a clean restart.
    start_run(16'd5, 8'd2, 8'd0, 4'b0100);
    @(negedge clk);
    @(negedge clk);
    check("x_pre_cnt", 64'(pkt_count), 64'd1);
    rst = 1'b1;
    #1;
    check("x_valid", 64'(axis_out_tvalid), 64'd0);
    check("x_busy", 64'(busy), 64'd0);
    check("x_done", 64'(done), 64'd0);
    check("x_data", 64'(|axis_out_tdata), 64'd0);
    check("x_dest", 64'(axis_out_tdest), 64'd0);
    check("x_cnt", 64'(pkt_count), 64'd0);
    @(negedge clk);
    check("x_no_done", 64'(done), 64'd0);
    rst = 1'b0;
    start_run(16'd5, 8'd2, 8'd0, 4'b0100);
    check("x_busy_new", 64'(busy), 64'd1);
    check_flit("x", 0, 0, 2, 1'b0);
    seen = 0;
    for (int c = 0; c < 50; c++) begin
      if (done) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    check("x_done_seen", 64'(seen), 64'd1);
    check("x_cnt_end", 64'(pkt_count), 64'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
